intr_ctrl: RTL and testbench
============================

// Module: intr_ctrl
// PURPOSE
//  Prioritised, nestable interrupt controller that drives the CP0 register block's exception interface.
//  - Takes three external request lines and edge-detects them into pending bits.
//  - Masks them with CP0 INM/IE, then arbitrates by fixed priority against the in-service level.
//  - Issues one entry event: BK pulse, one-cycle nonzero code, handler vector.
//  - Tracks in-service sources and retires the highest one on eret.
//  - Sits between the IRQ pins and CP0/PC-select logic in the pipeline top level.
// PARAMETERS
//  VEC_BASE    32'h0000_0100  handler vector for code 1
//  VEC_STRIDE  32'h0000_0010  address step between successive codes
// PORTS
//  in_CLK     in   1   system clock, all state on posedge
//  in_RST_N   in   1   reset, synchronous, active-low
//  in_IRQ     in   3   request lines, bit i-1 = source i; rising edge requests service
//  in_IE      in   1   CP0 global interrupt enable
//  in_INM     in   4   CP0 mask; bit i=1 masks source i (bit0 unused)
//  in_STALL   in   1   pipeline stalled; no new entry issued while high
//  in_ERET    in   1   eret retiring in WB, one-cycle pulse
//  out_BK     out  1   entry pulse to CP0, one cycle
//  out_NIE    out  1   new IE value CP0 loads on BK/eret
//  out_CODE   out  2   source code being entered, nonzero only during the BK cycle
//  out_VEC    out  32  handler address, valid while out_BK=1
//  out_INSVC  out  3   in-service bitmask
//  out_PEND   out  3   pending bitmask
// BEHAVIOUR
//  - Reset (in_RST_N=0 at posedge): state=IDLE; pending, in-service, IRQ sync regs = 0.
//    Outputs: out_BK=0, out_CODE=0, out_VEC=0, out_NIE=1.
//  - Reset has the same effect mid-operation, in any state.
//  - Edge detect: irq_q <= in_IRQ each cycle. Rise = in_IRQ & ~irq_q sets pend[i].
//    If a rise and a take of the same source coincide, set wins and pend stays 1.
//  - Eligibility: elig = pend & ~in_INM[3:1].
//    best = highest set index of elig (3 highest priority).
//    cur = highest set index of in-service, 0 if none.
//  - Take condition: state==IDLE && in_IE && !in_STALL && best>cur && !in_ERET.
//  - FSM, registered outputs:
//    - IDLE -> ENTER on take. Next cycle: out_BK=1, out_CODE=best, out_NIE=0,
//      out_VEC=VEC_BASE+(best-1)*VEC_STRIDE (mod 2^32), pend[best]<=0, insvc[best]<=1.
//    - ENTER -> GAP unconditionally. out_BK=0, out_CODE=0.
//      GAP holds out_CODE=0 for one cycle so CP0 always sees a fresh 0->nonzero code edge.
//    - GAP -> IDLE unconditionally. Minimum spacing between two entries is 3 cycles.
//  - Latency: an unmasked edge at cycle N (IDLE, IE=1, no stall) gives out_BK at N+2.
//    N+1 is the sync/pend cycle; N+2 is ENTER.
//  - eret: in any state, in_ERET=1 clears the highest set in-service bit next cycle and sets out_NIE=1.
//    - eret with in-service empty: in-service unchanged, out_NIE=1.
//    - eret in the same cycle as a take condition: eret wins and the take is re-evaluated next cycle.
//  - Nesting: a lower- or equal-priority pending source waits until eret lowers cur.
//    Masked sources stay pending until unmasked.
//  - in_STALL or in_IE=0 only defers entry; pending is never lost.
//  - out_NIE holds its last value between BK/eret events.
// STRUCTURE
//  - Shared package intr_pkg: code constants INT_NONE=2'd0, INT_SRC1..INT_SRC3.
//    It also holds FSM encodings S_IDLE/S_ENTER/S_GAP and the VEC_BASE/VEC_STRIDE defaults.
//  - Sub-module intr_prio_enc: 3-bit vector -> 2-bit highest-set index, 0 if empty.
//    Instantiated twice, once for best and once for cur.
// TESTING
//  1. Reset: in_RST_N=0 for 2 clocks with in_IRQ=3'b111.
//     -> out_BK=0, out_CODE=0, out_PEND=0, out_INSVC=0, out_NIE=1.
//  2. Single entry: IE=1, INM=0, in_IRQ[0] rises at cycle 10.
//     -> cycle 12: out_BK=1, out_CODE=1, out_VEC=32'h100, out_NIE=0.
//     -> cycle 13: out_CODE=0; INSVC=3'b001, PEND=0.
//  3. Nesting: source1 in service, source3 rises.
//     -> entry with CODE=3, VEC=32'h120; INSVC=3'b101.
//     -> eret -> INSVC=3'b001, NIE=1. Second eret -> INSVC=0.
//  4. Priority blocking: source2 in service, source1 rises.
//     -> PEND=3'b001 and no BK until eret. BK with CODE=1 appears 2 cycles after the eret cycle.
//  5. Masking/stall: INM=4'b0100 and source2 rises -> PEND=3'b010, no BK.
//     -> clear INM while in_STALL=1 -> no BK. Drop stall -> BK, CODE=2, next cycle.
//  6. Collision: take condition with in_ERET=1 in the same cycle -> no BK that cycle, BK the cycle after.
//     -> rise of source1 in its ENTER cycle -> PEND[0] remains 1.

Source files
------------

// File: rtl/intr_pkg.sv
// Purpose : shared constants for the interrupt controller (source codes, FSM states, vector defaults).
// Latency : n/a (package only).
// Backpressure: n/a.
package intr_pkg;

    // Source codes; code k corresponds to request line bit k-1.
    localparam logic [1:0] INT_NONE = 2'd0;
    localparam logic [1:0] INT_SRC1 = 2'd1;
    localparam logic [1:0] INT_SRC2 = 2'd2;
    localparam logic [1:0] INT_SRC3 = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTER = 2'd1,
        S_GAP   = 2'd2
    } intr_state_t;

    localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
    localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0010;

    // Handler address for a nonzero code; wraps modulo 2^32.
    function automatic logic [31:0] code_vec(input logic [1:0]  code,
                                             input logic [31:0] base,
                                             input logic [31:0] stride);
        logic [31:0] w_idx;
        w_idx = {30'd0, code} - 32'd1;
        return base + w_idx * stride;
    endfunction

    // One-hot source bit for a code; empty for INT_NONE.
    function automatic logic [2:0] code_mask(input logic [1:0] code);
        logic [2:0] w_m;
        w_m = 3'b000;
        if (code != INT_NONE) begin
            w_m[code - 2'd1] = 1'b1;
        end
        return w_m;
    endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Purpose : fixed-priority encoder, 3-bit source vector -> highest set code (0 if empty).
// Latency : combinational.
// Backpressure: none.
// Ports   : i_vec (bit k-1 = source k), o_idx (2-bit code).
module intr_prio_enc
    import intr_pkg::*;
(
    input  logic [2:0] i_vec,
    output logic [1:0] o_idx
);

    always_comb begin
        o_idx = INT_NONE;
        if (i_vec[2]) begin
            o_idx = INT_SRC3;
        end else if (i_vec[1]) begin
            o_idx = INT_SRC2;
        end else if (i_vec[0]) begin
            o_idx = INT_SRC1;
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// Purpose : nestable fixed-priority interrupt controller feeding the CP0 exception interface.
// Latency : IRQ rising edge at cycle N -> out_BK at N+2 (IDLE, IE=1, no stall); entries >= 3 cycles apart.
// Backpressure: in_STALL / in_IE=0 / in_ERET defer entry; pending requests are never dropped.
// Ports   : in_CLK, in_RST_N (sync, active-low), in_IRQ[2:0], in_IE, in_INM[3:0], in_STALL, in_ERET;
//           out_BK, out_NIE, out_CODE[1:0], out_VEC[31:0], out_INSVC[2:0], out_PEND[2:0].
module intr_ctrl
    import intr_pkg::*;
#(
    parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
    parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE
) (
    input  logic        in_CLK,
    input  logic        in_RST_N,
    input  logic [2:0]  in_IRQ,
    input  logic        in_IE,
    input  logic [3:0]  in_INM,
    input  logic        in_STALL,
    input  logic        in_ERET,
    output logic        out_BK,
    output logic        out_NIE,
    output logic [1:0]  out_CODE,
    output logic [31:0] out_VEC,
    output logic [2:0]  out_INSVC,
    output logic [2:0]  out_PEND
);

    intr_state_t r_state;
    logic [2:0]  r_irq_q;
    logic [2:0]  r_pend;
    logic [2:0]  r_insvc;
    logic        r_bk;
    logic        r_nie;
    logic [1:0]  r_code;
    logic [31:0] r_vec;

    logic [2:0]  w_rise;
    logic [2:0]  w_elig;
    logic [1:0]  w_best;
    logic [1:0]  w_cur;
    logic        w_take;
    logic [2:0]  w_take_mask;
    logic [2:0]  w_ret_mask;
    logic        w_unused;

    // INM bit 0 has no source behind it.
    assign w_unused = in_INM[0];

    assign w_rise = in_IRQ & ~r_irq_q;
    assign w_elig = r_pend & ~in_INM[3:1];

    intr_prio_enc u_best_enc (
        .i_vec (w_elig),
        .o_idx (w_best)
    );

    intr_prio_enc u_cur_enc (
        .i_vec (r_insvc),
        .o_idx (w_cur)
    );

    // eret has precedence over a new entry; the entry is re-evaluated next cycle.
    assign w_take = (r_state == S_IDLE) && in_IE && !in_STALL
                    && (w_best > w_cur) && !in_ERET;

    assign w_take_mask = w_take  ? code_mask(w_best) : 3'b000;
    assign w_ret_mask  = in_ERET ? code_mask(w_cur)  : 3'b000;

    always_ff @(posedge in_CLK) begin
        if (!in_RST_N) begin
            r_state <= S_IDLE;
            r_irq_q <= 3'b000;
            r_pend  <= 3'b000;
            r_insvc <= 3'b000;
            r_bk    <= 1'b0;
            r_nie   <= 1'b1;
            r_code  <= INT_NONE;
            r_vec   <= 32'd0;
        end else begin
            r_irq_q <= in_IRQ;
            // A fresh rise on the source being taken re-arms it (set wins).
            r_pend  <= (r_pend & ~w_take_mask) | w_rise;
            // Take and eret are mutually exclusive, so set/clear never collide.
            r_insvc <= (r_insvc & ~w_ret_mask) | w_take_mask;
            if (in_ERET) begin
                r_nie <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_bk   <= 1'b0;
                    r_code <= INT_NONE;
                    if (w_take) begin
                        r_state <= S_ENTER;
                        r_bk    <= 1'b1;
                        r_code  <= w_best;
                        r_vec   <= code_vec(w_best, VEC_BASE, VEC_STRIDE);
                        r_nie   <= 1'b0;
                    end
                end
                S_ENTER: begin
                    r_state <= S_GAP;
                    r_bk    <= 1'b0;
                    r_code  <= INT_NONE;
                end
                // GAP keeps CODE at 0 one more cycle so CP0 sees a clean 0->code edge.
                S_GAP: begin
                    r_state <= S_IDLE;
                    r_bk    <= 1'b0;
                    r_code  <= INT_NONE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_bk    <= 1'b0;
                    r_code  <= INT_NONE;
                end
            endcase
        end
    end

    assign out_BK    = r_bk;
    assign out_NIE   = r_nie;
    assign out_CODE  = r_code;
    assign out_VEC   = r_vec;
    assign out_INSVC = r_insvc;
    assign out_PEND  = r_pend;

endmodule

// File: tb/tb_intr_ctrl.sv
// Purpose : self-checking bench for intr_ctrl; reference model plus entry scoreboard.
// Latency : n/a.
// Backpressure: n/a.
module tb_intr_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  irq;
    logic        ie;
    logic [3:0]  inm;
    logic        stall;
    logic        eret;
    logic        out_bk;
    logic        out_nie;
    logic [1:0]  out_code;
    logic [31:0] out_vec;
    logic [2:0]  out_insvc;
    logic [2:0]  out_pend;

    always #5 clk = ~clk;

    intr_ctrl dut (
        .in_CLK    (clk),
        .in_RST_N  (rst_n),
        .in_IRQ    (irq),
        .in_IE     (ie),
        .in_INM    (inm),
        .in_STALL  (stall),
        .in_ERET   (eret),
        .out_BK    (out_bk),
        .out_NIE   (out_nie),
        .out_CODE  (out_code),
        .out_VEC   (out_vec),
        .out_INSVC (out_insvc),
        .out_PEND  (out_pend)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          code;
        logic [31:0] vec;
        int          at;
    } exp_t;
    exp_t expq[$];

    // Reference model state as seen after the most recent clock edge.
    bit [2:0] m_pend  = 3'b000;
    int       m_stack[$];          // in-service codes, most recent (highest) last
    bit [2:0] m_prev  = 3'b000;
    bit       m_nie   = 1'b1;
    int       m_busy  = 0;         // cycles of entry blackout still to run

    function automatic logic [31:0] vec_of(input int c);
        case (c)
            1:       return 32'h0000_0100;
            2:       return 32'h0000_0110;
            3:       return 32'h0000_0120;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [2:0] stack_mask();
        logic [2:0] mk;
        mk = 3'b000;
        foreach (m_stack[k]) mk[m_stack[k]-1] = 1'b1;
        return mk;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Apply one cycle of inputs, predict the outcome, advance past the edge.
    task automatic step(input bit r, input bit [2:0] q, input bit e,
                        input bit [3:0] m, input bit s, input bit er);
        bit [2:0] n_pend;
        bit [2:0] n_prev;
        bit       n_nie;
        int       n_busy;
        int       n_stack[$];
        int       best;
        int       cur;
        rst_n = r; irq = q; ie = e; inm = m; stall = s; eret = er;
        n_stack = m_stack;
        n_nie   = m_nie;
        if (!r) begin
            n_pend = 3'b000;
            n_stack.delete();
            n_prev = 3'b000;
            n_nie  = 1'b1;
            n_busy = 0;
        end else begin
            cur  = (m_stack.size() > 0) ? m_stack[$] : 0;
            best = 0;
            for (int i = 1; i <= 3; i++) if (m_pend[i-1] && !m[i]) best = i;
            n_pend = m_pend | (q & ~m_prev);
            n_busy = (m_busy > 0) ? m_busy - 1 : 0;
            if (er) begin
                if (n_stack.size() > 0) void'(n_stack.pop_back());
                n_nie = 1'b1;
            end else if (m_busy == 0 && e && !s && best > cur) begin
                n_pend = (m_pend & ~(3'b001 << (best - 1))) | (q & ~m_prev);
                n_stack.push_back(best);
                n_nie  = 1'b0;
                n_busy = 2;
                expq.push_back('{best, vec_of(best), cyc + 1});
            end
            n_prev = q;
        end
        @(posedge clk);
        #1;
        m_pend  = n_pend;
        m_stack = n_stack;
        m_prev  = n_prev;
        m_nie   = n_nie;
        m_busy  = n_busy;
    endtask

    // Monitor: compares visible state each cycle and pops the scoreboard on every BK.
    initial begin
        exp_t ex;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("pend",  {29'd0, out_pend},  {29'd0, m_pend});
                chk("insvc", {29'd0, out_insvc}, {29'd0, stack_mask()});
                chk("nie",   {31'd0, out_nie},   {31'd0, m_nie});
                if (out_bk) begin
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_bk cycle %0d: got BK code %0d expected none", cyc, out_code);
                    end else begin
                        ex = expq.pop_front();
                        chk("bk_code",  {30'd0, out_code}, ex.code);
                        chk("bk_vec",   out_vec, ex.vec);
                        chk("bk_cycle", cyc, ex.at);
                    end
                end else begin
                    chk("code_idle", {30'd0, out_code}, 32'd0);
                    if (expq.size() > 0 && expq[0].at <= cyc) begin
                        ex = expq.pop_front();
                        checks++;
                        errors++;
                        $display("FAIL missed_bk cycle %0d: got no BK expected code %0d", cyc, ex.code);
                    end
                end
            end
        end
    end

    initial begin
        bit [2:0] r_irq;
        bit [3:0] r_inm;
        rst_n = 1'b0; irq = 3'b111; ie = 1'b0; inm = 4'b0; stall = 1'b0; eret = 1'b0;

        // Reset with all request lines high.
        step(0, 3'b111, 0, 4'b0, 0, 0);
        mon_en = 1'b1;
        step(0, 3'b111, 0, 4'b0, 0, 0);
        step(0, 3'b000, 0, 4'b0, 0, 0);
        step(0, 3'b000, 0, 4'b0, 0, 0);

        // Single entry of source 1.
        repeat (3) step(1, 3'b000, 1, 4'b0, 0, 0);
        repeat (5) step(1, 3'b001, 1, 4'b0, 0, 0);

        // Nesting: source 3 on top of source 1, then unwind.
        repeat (5) step(1, 3'b101, 1, 4'b0, 0, 0);
        step(1, 3'b101, 1, 4'b0, 0, 1);
        repeat (2) step(1, 3'b101, 1, 4'b0, 0, 0);
        step(1, 3'b101, 1, 4'b0, 0, 1);
        repeat (2) step(1, 3'b000, 1, 4'b0, 0, 0);

        // Priority blocking: source 2 in service, source 1 waits for eret.
        repeat (5) step(1, 3'b010, 1, 4'b0, 0, 0);
        repeat (6) step(1, 3'b011, 1, 4'b0, 0, 0);
        step(1, 3'b011, 1, 4'b0, 0, 1);
        repeat (5) step(1, 3'b000, 1, 4'b0, 0, 0);
        step(1, 3'b000, 1, 4'b0, 0, 1);
        repeat (3) step(1, 3'b000, 1, 4'b0, 0, 0);

        // Masking then stall deferral.
        repeat (4) step(1, 3'b010, 1, 4'b0100, 0, 0);
        repeat (3) step(1, 3'b010, 1, 4'b0000, 1, 0);
        repeat (4) step(1, 3'b010, 1, 4'b0000, 0, 0);
        step(1, 3'b000, 1, 4'b0, 0, 1);

        // Collision: eret in a take cycle, then a rise during ENTER.
        step(1, 3'b100, 0, 4'b0, 0, 0);
        step(1, 3'b100, 1, 4'b0, 0, 1);
        step(1, 3'b100, 1, 4'b0, 0, 0);
        step(1, 3'b101, 1, 4'b0, 0, 0);
        repeat (4) step(1, 3'b101, 1, 4'b0, 0, 0);

        // Mid-operation reset.
        step(0, 3'b000, 1, 4'b0, 0, 0);
        step(1, 3'b000, 1, 4'b0, 0, 0);

        // Randomised traffic.
        r_irq = 3'b000;
        r_inm = 4'b0000;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) r_irq = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) r_inm = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 299) != 0),
                 r_irq,
                 ($urandom_range(0, 7) != 0),
                 r_inm,
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 5) == 0));
        end

        // Drain: every predicted entry must have been seen.
        repeat (5) step(1, 3'b000, 0, 4'b0, 0, 0);
        @(negedge clk);
        chk("drain", expq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
